uart_apb_arbiter: RTL and testbench
===================================

Name: uart_apb_arbiter

Overview:
- Shares one APB UART slave port between NUM_REQ on-chip requesters (CPU shim, DMA, debug) and generates the APB master side.
- Accepts single-beat read/write requests, arbitrates round-robin and runs the APB SETUP/ACCESS sequence.
- Waits on PREADY, with a timeout, and returns read data and status to the granted requester.
- Sits in the PCLK domain, directly in front of the UART's PSEL/PENABLE/PWRITE/PADDR/PWDATA inputs.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 1024, maximum ACCESS cycles without PREADY before aborting.

Ports:
- PCLK  in  1  APB clock.
- PRESETn  in  1  reset.
- req_valid  in  NUM_REQ  per-requester request pending.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*12  per-requester PADDR; slot i is bits [12i+11:12i].
- req_wdata  in  NUM_REQ*8  per-requester PWDATA.
- req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse.
- rsp_rdata  out  32  read data, valid with rsp_valid.
- rsp_err  out  1  timeout flag, valid with rsp_valid.
- PSEL, PENABLE, PWRITE  out  1 each  APB master controls.
- PADDR  out  12  APB address.
- PWDATA  out  8  APB write data.
- PREADY  in  1  from UART.
- PRDATA  in  32  from UART.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset: PRESETn is asynchronous, active-low.
  - All outputs go to 0 and the FSM goes to IDLE.
  - Round-robin pointer is 0; timeout counter is 0.
  - Reset mid-transfer aborts immediately. No rsp_valid is issued for the aborted request.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - If any req_valid is set, grant the first set bit at or after the pointer, wrapping NUM_REQ-1 to 0.
  - Pulse req_ready[g] and capture write, addr and wdata into internal registers.
  - Advance the pointer to (g+1) mod NUM_REQ. Next state is SETUP.
  - With no request, stay in IDLE.
- SETUP: PSEL=1, PENABLE=0, address/data/write driven from the captured registers. Lasts exactly one cycle, then ACCESS.
- ACCESS: PSEL=1, PENABLE=1.
  - Sampling PREADY=1 captures PRDATA (read) or 0 (write) into rsp_rdata, sets rsp_err=0 and moves to RESP.
  - Each cycle with PREADY=0 increments the timeout counter.
  - When the counter reaches TIMEOUT_CYCLES-1 with PREADY=0: rsp_rdata=0, rsp_err=1, move to RESP.
- RESP:
  - PSEL=PENABLE=0. rsp_valid[g] pulses for one cycle; rsp_rdata and rsp_err are held until the next RESP.
  - Counter clears and the FSM returns to IDLE.
- Latency: req_ready at cycle N, SETUP at N+1, ACCESS at N+2. With zero-wait PREADY, rsp_valid is at N+3. Minimum request-to-request spacing is 4 cycles.
- Handshake:
  - Requester holds req_valid and its fields stable until req_ready.
  - Deasserting req_valid after the grant does not cancel the captured transfer.
  - A requester may raise a new req_valid in the same cycle as its rsp_valid. It is arbitrated at the next IDLE.
- Outside SETUP and ACCESS, PADDR/PWDATA/PWRITE are held at their last values; PSEL=0 and PENABLE=0.
- Simultaneous requests: exactly one grant per IDLE cycle. Over NUM_REQ consecutive transactions with all requesters continuously requesting, each requester is granted exactly once.
- The pointer only advances on a grant.
- busy = (state != IDLE).

Optional Feature:
- Macro: UART_ARB_PRIORITY_EN.
- When defined: requester 0 is fixed highest priority and preempts the round-robin choice in IDLE. The pointer rotates only among requesters 1..NUM_REQ-1 and does not advance when requester 0 is granted.
- When undefined: pure round-robin among all requesters, as above.

Decomposition:
- Package uart_arb_pkg holds:
  - typedef enum logic [1:0] arb_state_t {IDLE, SETUP, ACCESS, RESP};
  - localparam APB_AW=12, APB_DW=8, APB_RW=32.
- Sub-module rr_arbiter (parameter NUM_REQ) contains:
  - combinational rotate-and-find-first producing one-hot grant plus a grant_any flag;
  - the registered pointer, updated on an advance strobe.

Test Plan:
- Single write, req 1 (addr 12'h104, wdata 8'hA5, PREADY tied 1) -> req_ready[1] at N; PSEL at N+1; PENABLE at N+2 with PADDR=12'h104, PWDATA=8'hA5, PWRITE=1; rsp_valid[1] at N+3 with rsp_err=0.
- Read, req 2, PREADY delayed 5 cycles, PRDATA=32'h0000_005A -> PENABLE held 6 cycles; rsp_rdata=32'h5A; rsp_valid[2] one cycle.
- All 4 requesting continuously from reset -> grant order 0,1,2,3,0,1.
- PREADY stuck 0 with TIMEOUT_CYCLES=16 -> exactly 16 ACCESS cycles; rsp_err=1; rsp_rdata=0; FSM back to IDLE.
- PRESETn asserted during ACCESS -> PSEL, PENABLE, req_ready, rsp_valid and busy all 0 immediately; after release the next grant goes to req 0.
- UART_ARB_PRIORITY_EN defined, reqs 0 and 3 held continuously -> req 0 granted every transaction; req 3 only after req 0 deasserts.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and APB widths for the UART APB arbiter slice.
package uart_arb_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} arb_state_t;

    localparam int APB_AW = 12;
    localparam int APB_DW = 8;
    localparam int APB_RW = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin find-first arbiter with registered pointer; combinational grant, pointer moves on advance.
// UART_ARB_PRIORITY_EN: requester 0 preempts and the pointer rotates only among 1..NUM_REQ-1.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic               PCLK,
    input  logic               PRESETn,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_any
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0]      ptr;
    logic [PW-1:0]      gidx;
    logic [PW:0]        idx;
    logic [NUM_REQ-1:0] cand;

    always_comb begin
        cand      = req;
        grant_any = 1'b0;
        gidx      = '0;
        idx       = '0;
`ifdef UART_ARB_PRIORITY_EN
        cand[0] = 1'b0;
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, ptr} + (PW+1)'(i);
            if (idx >= (PW+1)'(NUM_REQ))
                idx = idx - (PW+1)'(NUM_REQ);
            if (!grant_any && cand[idx[PW-1:0]]) begin
                grant_any = 1'b1;
                gidx      = idx[PW-1:0];
            end
        end
`ifdef UART_ARB_PRIORITY_EN
        if (req[0]) begin
            grant_any = 1'b1;
            gidx      = '0;
        end
`endif
        grant = grant_any ? (NUM_REQ'(1) << gidx) : '0;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ptr <= '0;
        end else if (advance && grant_any) begin
`ifdef UART_ARB_PRIORITY_EN
            // Requester 0 sits outside the rotation, so its grants leave the pointer alone.
            if (gidx != '0)
                ptr <= (gidx == PW'(NUM_REQ-1)) ? '0 : gidx + PW'(1);
`else
            ptr <= (gidx == PW'(NUM_REQ-1)) ? '0 : gidx + PW'(1);
`endif
        end
    end

endmodule

// File: rtl/uart_apb_arbiter.sv
// Shares one APB UART slave among NUM_REQ requesters; grant->SETUP->ACCESS->RESP, rsp at grant+3 with zero wait.
// PREADY wait states stretch ACCESS up to TIMEOUT_CYCLES; UART_ARB_PRIORITY_EN makes requester 0 preemptive.
module uart_apb_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*APB_AW-1:0] req_addr,
    input  logic [NUM_REQ*APB_DW-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [APB_RW-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [APB_AW-1:0]         PADDR,
    output logic [APB_DW-1:0]         PWDATA,
    input  logic                      PREADY,
    input  logic [APB_RW-1:0]         PRDATA,
    output logic                      busy
);
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    arb_state_t         state, state_nxt;
    logic               run;
    logic [NUM_REQ-1:0] grant, grant_reg;
    logic               grant_any, accept, timeout_hit;
    logic               sel_write;
    logic [APB_AW-1:0]  sel_addr;
    logic [APB_DW-1:0]  sel_wdata;
    logic [TW-1:0]      tcnt;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .req       (req_valid),
        .advance   (accept),
        .grant     (grant),
        .grant_any (grant_any)
    );

    // run keeps req_ready low while reset is held even though the arbiter is combinational.
    assign accept      = (state == IDLE) && run && grant_any;
    assign req_ready   = accept ? grant : '0;
    assign rsp_valid   = (state == RESP) ? grant_reg : '0;
    assign PSEL        = (state == SETUP) || (state == ACCESS);
    assign PENABLE     = (state == ACCESS);
    assign busy        = (state != IDLE);
    assign timeout_hit = (tcnt == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_write = sel_write | req_write[i];
                sel_addr  = sel_addr  | req_addr[i*APB_AW +: APB_AW];
                sel_wdata = sel_wdata | req_wdata[i*APB_DW +: APB_DW];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (PREADY || timeout_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            run       <= 1'b0;
            grant_reg <= '0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            tcnt      <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            run   <= 1'b1;
            if (accept) begin
                grant_reg <= grant;
                PWRITE    <= sel_write;
                PADDR     <= sel_addr;
                PWDATA    <= sel_wdata;
            end
            if (state == ACCESS) begin
                if (PREADY) begin
                    rsp_rdata <= PWRITE ? '0 : PRDATA;
                    rsp_err   <= 1'b0;
                    tcnt      <= '0;
                end else if (timeout_hit) begin
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b1;
                end else begin
                    tcnt <= tcnt + TW'(1);
                end
            end else if (state == RESP) begin
                tcnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_apb_arbiter.sv
// Scoreboard bench for uart_apb_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=16) with a wait-state APB slave model.
module tb_uart_apb_arbiter;
    localparam int N  = 4;
    localparam int TO = 16;

    logic          PCLK = 1'b0;
    logic          PRESETn = 1'b0;
    logic [N-1:0]  req_valid, req_write, req_ready, rsp_valid;
    logic [N*12-1:0] req_addr;
    logic [N*8-1:0]  req_wdata;
    logic [31:0]   rsp_rdata, PRDATA;
    logic          rsp_err, PSEL, PENABLE, PWRITE, PREADY, busy;
    logic [11:0]   PADDR;
    logic [7:0]    PWDATA;

    uart_apb_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA), .busy(busy)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        int          idx;
        logic        wr;
        logic [11:0] addr;
        logic [7:0]  wd;
        logic        err;
        logic [31:0] rd;
        int          acc;
    } txn_t;

    txn_t sb[$];
    int   order[$];
    int   n_cmp = 0, n_bad = 0;
    int   cyc = 0, mptr = 0, grant_cyc = 0, acc_cnt = 0, wcnt = 0;
    int   pready_wait = 0;
    int   m_e;
    txn_t m_t;

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic int model_pick(logic [N-1:0] v, int p);
`ifdef UART_ARB_PRIORITY_EN
        if (v[0]) return 0;
        v[0] = 1'b0;
`endif
        for (int i = 0; i < N; i++)
            if (v[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    // APB slave: PREADY rises after pready_wait stalled ACCESS cycles.
    always @(negedge PCLK) begin
        if (PSEL && PENABLE) begin
            PREADY = (wcnt >= pready_wait);
            wcnt++;
        end else begin
            PREADY = 1'b0;
            wcnt   = 0;
        end
    end

    always @(negedge PCLK) begin
        if (PRESETn) begin
            if (req_ready != '0) begin
                m_e = model_pick(req_valid, mptr);
                chk("grant", {28'h0, req_ready}, (m_e < 0) ? 32'h0 : (32'h1 << m_e));
                if (m_e >= 0) begin
                    m_t.idx  = m_e;
                    m_t.wr   = req_write[m_e];
                    m_t.addr = req_addr[12*m_e +: 12];
                    m_t.wd   = req_wdata[8*m_e +: 8];
                    m_t.err  = (pready_wait >= TO);
                    m_t.rd   = (m_t.err || m_t.wr) ? 32'h0 : PRDATA;
                    m_t.acc  = m_t.err ? TO : pready_wait + 1;
                    sb.push_back(m_t);
                    order.push_back(m_e);
`ifdef UART_ARB_PRIORITY_EN
                    if (m_e != 0) mptr = (m_e + 1) % N;
`else
                    mptr = (m_e + 1) % N;
`endif
                end
                grant_cyc = cyc;
                acc_cnt   = 0;
            end
            if (PSEL && !PENABLE) chk("setup_cycle", cyc, grant_cyc + 1);
            if (PSEL && PENABLE) begin
                acc_cnt++;
                if (acc_cnt == 1 && sb.size() > 0) begin
                    chk("access_cycle", cyc, grant_cyc + 2);
                    chk("paddr", {20'h0, PADDR}, {20'h0, sb[0].addr});
                    chk("pwdata", {24'h0, PWDATA}, {24'h0, sb[0].wd});
                    chk("pwrite", {31'h0, PWRITE}, {31'h0, sb[0].wr});
                end
            end
            if (rsp_valid != '0) begin
                if (sb.size() == 0) begin
                    chk("rsp_spurious", {28'h0, rsp_valid}, 32'h0);
                end else begin
                    m_t = sb.pop_front();
                    chk("rsp_valid", {28'h0, rsp_valid}, 32'h1 << m_t.idx);
                    chk("rsp_err", {31'h0, rsp_err}, {31'h0, m_t.err});
                    chk("rsp_rdata", rsp_rdata, m_t.rd);
                    chk("access_len", acc_cnt, m_t.acc);
                    chk("rsp_cycle", cyc, grant_cyc + 2 + acc_cnt);
                end
            end
        end
    end

    task automatic set_req(int i, logic wr, logic [11:0] a, logic [7:0] d);
        req_write[i]         = wr;
        req_addr[12*i +: 12] = a;
        req_wdata[8*i +: 8]  = d;
        req_valid[i]         = 1'b1;
    endtask

    task automatic one_req(int i, logic wr, logic [11:0] a, logic [7:0] d);
        bit got = 0;
        @(posedge PCLK); #1;
        set_req(i, wr, a, d);
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge PCLK);
            if (req_ready[i]) got = 1;
        end
        if (!got) chk("req_ready_wait", 32'h0, 32'h1);
        @(posedge PCLK); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic drain(int budget);
        bit done = 0;
        for (int k = 0; k < budget && !done; k++) begin
            @(negedge PCLK);
            if (sb.size() == 0 && !busy) done = 1;
        end
        chk("drain", {31'h0, done}, 32'h1);
    endtask

    task automatic wait_grants(int n, int budget);
        for (int k = 0; k < budget && order.size() < n; k++) @(negedge PCLK);
        chk("grant_count", (order.size() >= n) ? n : order.size(), n);
    endtask

    task automatic do_reset();
        PRESETn = 1'b0;
        sb.delete();
        order.delete();
        mptr = 0;
        #1;
        chk("rst_psel", {31'h0, PSEL}, 32'h0);
        chk("rst_penable", {31'h0, PENABLE}, 32'h0);
        chk("rst_req_ready", {28'h0, req_ready}, 32'h0);
        chk("rst_rsp_valid", {28'h0, rsp_valid}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
    endtask

    initial begin
        int exp_order[6];
`ifdef UART_ARB_PRIORITY_EN
        exp_order = '{0, 0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0, 1};
`endif
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        PRDATA = 32'h0; PREADY = 1'b0;

        // reset state
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        do_reset();
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_err", {31'h0, rsp_err}, 32'h0);
        chk("rst_paddr", {20'h0, PADDR}, 32'h0);
        @(posedge PCLK); #1 PRESETn = 1'b1;

        // single zero-wait write from requester 1
        pready_wait = 0;
        one_req(1, 1'b1, 12'h104, 8'hA5);
        drain(40);

        // read from requester 2 with five wait states
        pready_wait = 5;
        PRDATA = 32'h0000_005A;
        one_req(2, 1'b0, 12'h2C0, 8'h00);
        drain(40);

        // all four requesting continuously out of reset
        pready_wait = 0;
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, i[0], 12'h100 + 12'(i), 8'h10 + 8'(i));
        @(posedge PCLK); #1 PRESETn = 1'b1;
        wait_grants(6, 200);
        @(posedge PCLK); #1 req_valid = '0;
        for (int i = 0; i < 6; i++)
            chk($sformatf("order_%0d", i), (i < order.size()) ? order[i] : -1, exp_order[i]);
        drain(40);

        // PREADY stuck low: timeout response
        pready_wait = 1000;
        one_req(3, 1'b0, 12'h00C, 8'h00);
        drain(100);
        chk("busy_after_timeout", {31'h0, busy}, 32'h0);

        // reset during ACCESS, then next grant goes to requester 0
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 12'h200 + 12'(i), 8'h20 + 8'(i));
        begin
            bit seen = 0;
            for (int k = 0; k < 50 && !seen; k++) begin
                @(negedge PCLK);
                if (PENABLE) seen = 1;
            end
            chk("reached_access", {31'h0, seen}, 32'h1);
        end
        #2 do_reset();
        pready_wait = 0;
        @(posedge PCLK); #1 PRESETn = 1'b1;
        wait_grants(1, 20);
        chk("post_reset_grant", (order.size() > 0) ? order[0] : -1, 0);
        @(posedge PCLK); #1 req_valid = '0;
        drain(40);

        // scattered requests exercising pointer movement
        one_req(3, 1'b1, 12'h3F0, 8'h5C);
        drain(40);
        @(posedge PCLK); #1;
        set_req(0, 1'b0, 12'h010, 8'h00);
        set_req(2, 1'b1, 12'h020, 8'hC3);
        wait_grants(order.size() + 1, 20);
        @(posedge PCLK); #1 req_valid = '0;
        drain(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
